// File: rtl/bullet_hit_scanner_pkg.sv
// bullet_hit_scanner_pkg: bullet colour encodings, scanner states and the
// position/size field slices shared with the bullet store.
package bullet_hit_scanner_pkg;

    typedef enum logic [1:0] {
        COLOR_WHITE = 2'd0,
        COLOR_GREEN = 2'd1,
        COLOR_BLUE  = 2'd2,
        COLOR_NONE  = 2'd3
    } color_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_TEST,
        S_APPLY
    } state_e;

    // Upper byte: x for positions, width for sizes.
    function automatic logic [7:0] field_hi(input logic [15:0] v);
        return v[15:8];
    endfunction

    // Lower byte: y for positions, height for sizes.
    function automatic logic [7:0] field_lo(input logic [15:0] v);
        return v[7:0];
    endfunction

endpackage

// File: rtl/bullet_hit_scanner_aabb.sv
// aabb_overlap: combinational 8-bit box overlap; 9-bit edge sums never wrap,
// touching edges and empty boxes do not count.
module aabb_overlap
    import bullet_hit_scanner_pkg::*;
(
    input  logic [15:0] a_pos_i,
    input  logic [15:0] a_size_i,
    input  logic [15:0] b_pos_i,
    input  logic [15:0] b_size_i,
    output logic        hit_o
);

    logic [8:0] ax, ay, aw, ah, bx, by, bw, bh;

    assign ax = {1'b0, field_hi(a_pos_i)};
    assign ay = {1'b0, field_lo(a_pos_i)};
    assign aw = {1'b0, field_hi(a_size_i)};
    assign ah = {1'b0, field_lo(a_size_i)};
    assign bx = {1'b0, field_hi(b_pos_i)};
    assign by = {1'b0, field_lo(b_pos_i)};
    assign bw = {1'b0, field_hi(b_size_i)};
    assign bh = {1'b0, field_lo(b_size_i)};

    assign hit_o = (aw != 9'd0) && (ah != 9'd0) && (bw != 9'd0) && (bh != 9'd0) &&
                   (bx < ax + aw) && (ax < bx + bw) &&
                   (by < ay + ah) && (ay < by + bh);

endmodule

// File: rtl/bullet_hit_scanner.sv
// bullet_hit_scanner: per-frame scan of the bullet store against the player box;
// produces the hit mask that clears bullets and owns player HP, iframes and death.
module bullet_hit_scanner
    import bullet_hit_scanner_pkg::*;
#(
    parameter int NUM_BULLETS = 3,
    parameter int HP_MAX      = 20,
    parameter int DMG         = 4,
    parameter int HEAL        = 2,
    parameter int IFRAMES     = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [15:0] player_pos,
    input  logic [15:0] player_size,
    input  logic        player_moving,
    output logic [2:0]  bullet_index,
    input  logic [15:0] bullet_pos,
    input  logic [15:0] bullet_size,
    input  logic [1:0]  bullet_color,
    input  logic        bullet_render,
    output logic [7:0]  hit_mask,
    output logic        hit_valid,
    output logic [7:0]  hp,
    output logic        invuln,
    output logic        dead,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  scratch_q, scratch_d;
    logic [2:0]  ndmg_q, ndmg_d;
    logic [2:0]  nheal_q, nheal_d;
    logic [7:0]  hit_mask_q, hit_mask_d;
    logic        hit_valid_q, hit_valid_d;
    logic [7:0]  hp_q, hp_d;
    logic [7:0]  iframe_q, iframe_d;
    logic        dead_q, dead_d;

    logic        overlap;
    logic        slot_hit;
    logic        last_slot;
    logic [9:0]  hp_sum;
    logic [7:0]  hp_sat;
    color_e      col;

    aabb_overlap u_aabb (
        .a_pos_i  (player_pos),
        .a_size_i (player_size),
        .b_pos_i  (bullet_pos),
        .b_size_i (bullet_size),
        .hit_o    (overlap)
    );

    assign col       = color_e'(bullet_color);
    assign slot_hit  = bullet_render && (col != COLOR_NONE) && overlap &&
                       ((col != COLOR_BLUE) || player_moving);
    assign last_slot = (idx_q == 3'(NUM_BULLETS - 1));

    // Two's-complement in 10 bits: bit 9 set means the result went negative.
    assign hp_sum = {2'b00, hp_q}
                  - (invuln ? 10'd0 : 10'(ndmg_q) * 10'(DMG))
                  + 10'(nheal_q) * 10'(HEAL);
    assign hp_sat = hp_sum[9] ? 8'd0 :
                    (hp_sum > 10'(HP_MAX)) ? 8'(HP_MAX) : hp_sum[7:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scratch_d   = scratch_q;
        ndmg_d      = ndmg_q;
        nheal_d     = nheal_q;
        hit_mask_d  = hit_mask_q;
        hit_valid_d = 1'b0;
        hp_d        = hp_q;
        dead_d      = dead_q;
        iframe_d    = (frame_tick && iframe_q != 8'd0) ? iframe_q - 8'd1 : iframe_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick && !dead_q) begin
                    state_d   = S_ADDR;
                    idx_d     = 3'd0;
                    scratch_d = 8'd0;
                    ndmg_d    = 3'd0;
                    nheal_d   = 3'd0;
                end
            end
            S_ADDR: state_d = S_TEST;
            S_TEST: begin
                if (slot_hit) begin
                    scratch_d[idx_q] = 1'b1;
                    nheal_d = (col == COLOR_GREEN) ? nheal_q + 3'd1 : nheal_q;
                    ndmg_d  = (col == COLOR_GREEN) ? ndmg_q : ndmg_q + 3'd1;
                end
                state_d = last_slot ? S_APPLY : S_ADDR;
                idx_d   = last_slot ? idx_q : idx_q + 3'd1;
            end
            S_APPLY: begin
                hp_d        = hp_sat;
                hit_mask_d  = scratch_q;
                hit_valid_d = 1'b1;
                dead_d      = (hp_sat == 8'd0);
                iframe_d    = (ndmg_q != 3'd0 && !invuln) ? 8'(IFRAMES) : iframe_d;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            scratch_q   <= 8'd0;
            ndmg_q      <= 3'd0;
            nheal_q     <= 3'd0;
            hit_mask_q  <= 8'd0;
            hit_valid_q <= 1'b0;
            hp_q        <= 8'(HP_MAX);
            iframe_q    <= 8'd0;
            dead_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scratch_q   <= scratch_d;
            ndmg_q      <= ndmg_d;
            nheal_q     <= nheal_d;
            hit_mask_q  <= hit_mask_d;
            hit_valid_q <= hit_valid_d;
            hp_q        <= hp_d;
            iframe_q    <= iframe_d;
            dead_q      <= dead_d;
        end
    end

    assign bullet_index = idx_q;
    assign hit_mask     = hit_mask_q;
    assign hit_valid    = hit_valid_q;
    assign hp           = hp_q;
    assign invuln       = (iframe_q != 8'd0);
    assign dead         = dead_q;
    assign busy         = (state_q != S_IDLE);

endmodule
